// File: rtl/ahfp_add_mc.sv
// Multi-cycle IEEE-754 single-precision adder, Nios II custom-instruction handshake.
// Round-to-nearest-even, denormals flushed to zero, overflow saturates to infinity.
module ahfp_add_mc #(
  parameter int unsigned LATENCY_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {StIdle, StAlign, StAddsub, StNorm, StRound} state_t;

  state_t             state_q;
  logic               sa_q, sb_q, sign_q, sub_q, spec_q, zero_q;
  logic [7:0]         ea_q, eb_q;
  logic [23:0]        ma_q, mb_q;
  logic [31:0]        spec_val_q;
  logic [26:0]        xm_q, ym_q, nm_q;
  logic [27:0]        sum_q;
  logic signed [9:0]  exp_q;

  // Operand decode
  logic        inf_a, inf_b;
  logic [23:0] ma_d, mb_d;
  logic [31:0] spec_val_d;

  always_comb begin
    inf_a = &dataa[30:23];
    inf_b = &datab[30:23];
    ma_d  = (dataa[30:23] == 8'd0) ? 24'd0 : {1'b1, dataa[22:0]};
    mb_d  = (datab[30:23] == 8'd0) ? 24'd0 : {1'b1, datab[22:0]};
    if (inf_a && inf_b && (dataa[31] != datab[31])) spec_val_d = 32'h7FC0_0000;
    else if (inf_a)                                 spec_val_d = {dataa[31], 8'hFF, 23'd0};
    else                                            spec_val_d = {datab[31], 8'hFF, 23'd0};
  end

  // Alignment: larger magnitude becomes X, Y shifted right with sticky collection
  logic        a_ge_b, sx, lost;
  logic [7:0]  ex, ey, dsh;
  logic [23:0] mx, my;
  logic [26:0] y_ext, y_shr, y_mask, y_al;

  always_comb begin
    a_ge_b = {ea_q, ma_q[22:0]} >= {eb_q, mb_q[22:0]};
    sx     = a_ge_b ? sa_q : sb_q;
    ex     = a_ge_b ? ea_q : eb_q;
    ey     = a_ge_b ? eb_q : ea_q;
    mx     = a_ge_b ? ma_q : mb_q;
    my     = a_ge_b ? mb_q : ma_q;
    dsh    = ex - ey;
    y_ext  = {my, 3'b000};
    y_shr  = y_ext >> dsh;
    y_mask = (27'd1 << dsh) - 27'd1;
    lost   = |(y_ext & y_mask);
    if (dsh >= 8'd27) y_al = {26'd0, |my};
    else              y_al = {y_shr[26:1], y_shr[0] | lost};
  end

  logic [27:0] sum_d;

  always_comb begin
    if (sub_q) sum_d = {1'b0, xm_q} - {1'b0, ym_q};
    else       sum_d = {1'b0, xm_q} + {1'b0, ym_q};
  end

  // Normalisation
  logic              lz_found;
  logic [4:0]        lzc;
  logic [26:0]       norm_m;
  logic signed [9:0] norm_e;

  always_comb begin
    lzc      = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found) begin
        if (sum_q[i]) lz_found = 1'b1;
        else          lzc      = lzc + 5'd1;
      end
    end
    if (sum_q[27]) begin
      norm_m = {sum_q[27:2], sum_q[1] | sum_q[0]};
      norm_e = exp_q + 10'sd1;
    end else begin
      norm_m = sum_q[26:0] << lzc;
      norm_e = exp_q - $signed({5'd0, lzc});
    end
  end

  // Rounding and final packing
  logic              rnd_inc;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;
  logic [31:0]       result_d;

  always_comb begin
    rnd_inc = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    mant_r  = {1'b0, nm_q[26:3]} + {24'd0, rnd_inc};
    exp_r   = mant_r[24] ? exp_q + 10'sd1 : exp_q;
    frac_r  = mant_r[24] ? 23'd0 : mant_r[22:0];
    if (spec_q)                 result_d = spec_val_q;
    else if (zero_q)            result_d = {sign_q, 31'd0};
    else if (exp_r >= 10'sd255) result_d = {sign_q, 8'hFF, 23'd0};
    else                        result_d = {sign_q, exp_r[7:0], frac_r};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      done       <= 1'b0;
      result     <= 32'd0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= 8'd0;
      eb_q       <= 8'd0;
      ma_q       <= 24'd0;
      mb_q       <= 24'd0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      xm_q       <= 27'd0;
      ym_q       <= 27'd0;
      sum_q      <= 28'd0;
      exp_q      <= 10'sd0;
      nm_q       <= 27'd0;
      zero_q     <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q       <= dataa[31];
            sb_q       <= datab[31];
            ea_q       <= dataa[30:23];
            eb_q       <= datab[30:23];
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            spec_q     <= inf_a | inf_b;
            spec_val_q <= spec_val_d;
            state_q    <= StAlign;
          end
        end
        StAlign: begin
          sign_q  <= sx;
          sub_q   <= sa_q ^ sb_q;
          xm_q    <= {mx, 3'b000};
          ym_q    <= y_al;
          exp_q   <= $signed({2'b00, ex});
          state_q <= StAddsub;
        end
        StAddsub: begin
          sum_q   <= sum_d;
          state_q <= StNorm;
        end
        StNorm: begin
          // Exact cancellation always yields +0; underflow keeps the sign
          zero_q  <= (sum_q == 28'd0) || (norm_e <= 10'sd0);
          sign_q  <= (sum_q == 28'd0) ? 1'b0 : sign_q;
          nm_q    <= norm_m;
          exp_q   <= norm_e;
          state_q <= StNorm == StNorm ? StRound : StRound;
        end
        StRound: begin
          result  <= result_d;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  generate
    if (LATENCY_CHECK != 0) begin : g_lat_check
      logic       busy_q;
      logic [2:0] lat_cnt_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          busy_q    <= 1'b0;
          lat_cnt_q <= 3'd0;
        end else begin
          if (done) begin
            assert (lat_cnt_q == 3'd4)
              else $error("done after %0d enabled cycles", lat_cnt_q);
          end
          if (clk_en) begin
            if (state_q == StIdle && start) begin
              busy_q    <= 1'b1;
              lat_cnt_q <= 3'd0;
            end else if (busy_q) begin
              lat_cnt_q <= lat_cnt_q + 3'd1;
              if (state_q == StRound) busy_q <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_ahfp_add_mc.sv
// Scoreboard bench for ahfp_add_mc: driver queues expected results and latency,
// a negedge monitor matches each done pulse against the queue.
module tb_ahfp_add_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic        done;
  logic [31:0] result;

  ahfp_add_mc #(.LATENCY_CHECK(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic en_last = 1'b1;
  logic done_prev = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_last <= clk_en;
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_prev) begin
        vectors++;
        if (done !== !en_last) begin
          miscompares++;
          $display("FAIL done_width: done=%b required %b", done, !en_last);
        end
      end
      if (done === 1'b1 && !done_prev) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: done=1 with no operation outstanding, result=%h", result);
        end else begin
          e = sb.pop_front();
          vectors++;
          if (result !== e.res) begin
            miscompares++;
            $display("FAIL result: got %h required %h", result, e.res);
          end
          vectors++;
          if (cyc - e.t0 != e.lat) begin
            miscompares++;
            $display("FAIL latency: got %0d required %0d (result %h)", cyc - e.t0, e.lat, e.res);
          end
        end
      end
      done_prev = done;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.lat = lat;
    e.t0  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d operations without done, required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    push_exp(res, 4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  localparam int NV = 13;
  logic [31:0] va [NV] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4020_0000, 32'h3F80_0000,
                          32'h3F80_0000, 32'h3F80_0001, 32'h7F7F_FFFF, 32'h7F80_0000,
                          32'h0040_0000, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000,
                          32'h7F80_0000};
  logic [31:0] vb [NV] = '{32'h4000_0000, 32'hBF80_0000, 32'hBF40_0000, 32'h3380_0000,
                          32'h3380_0001, 32'h3380_0000, 32'h7F7F_FFFF, 32'h3F80_0000,
                          32'h0000_0000, 32'h3200_0000, 32'h3F80_0000, 32'h7F7F_FFFF,
                          32'hFF80_0000};
  logic [31:0] vr [NV] = '{32'h4040_0000, 32'h0000_0000, 32'h3FE0_0000, 32'h3F80_0000,
                          32'h3F80_0001, 32'h3F80_0002, 32'h7F80_0000, 32'h7F80_0000,
                          32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000,
                          32'h7FC0_0000};

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) run_op(va[i], vb[i], vr[i]);

    // Freeze three cycles while in NORM: latency stretches to 7
    @(negedge clk);
    dataa = 32'h3F80_0000;
    datab = 32'h4000_0000;
    start = 1'b1;
    push_exp(32'h4040_0000, 7);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("frozen_result", result, 32'h7FC0_0000);
      check("frozen_done", {31'd0, done}, 32'd0);
    end
    clk_en = 1'b1;
    drain();

    // start re-pulsed in ADDSUB must be ignored
    @(negedge clk);
    dataa = 32'h3F80_0000;
    datab = 32'h3F80_0000;
    start = 1'b1;
    push_exp(32'h4000_0000, 4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dataa = 32'h4000_0000;
    datab = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    // Reset in ALIGN aborts the operation
    @(negedge clk);
    dataa = 32'h4040_0000;
    datab = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    run_op(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahfp_add_mc.md
Name: ahfp_add_mc

Overview:
Multi-cycle IEEE-754 single-precision floating-point adder. It is packaged as a Nios II multi-cycle custom instruction using the clk/clk_en/reset/start/done handshake. It is the additive counterpart to the team's combinational subtractor and shares its flush-to-zero and saturation policy. Unlike the subtractor, it is registered and uses round-to-nearest-even, so the full 28-bit datapath is spread over four states.

Parameters:
LATENCY_CHECK, 1, when 1 an internal assertion flags done not occurring exactly 4 enabled cycles after start (simulation only, no hardware effect)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears FSM, done, result
clk_en  input  1  clock enable; when low all state (FSM, datapath regs, done, result) holds
start  input  1  request; sampled only in IDLE with clk_en high
dataa  input  32  operand A, IEEE-754 single; sampled with start
datab  input  32  operand B, IEEE-754 single; sampled with start
done  output  1  one enabled-cycle pulse, result valid
result  output  32  A+B; registered, holds until next done

Behaviour:
- Reset values: done=0, result=32'h0, FSM=IDLE, internal registers 0.
- Reset asserted mid-operation aborts the operation immediately; no done follows.
- Every transition below requires clk_en=1. With clk_en=0 everything freezes and latency stretches by the number of disabled cycles.
- FSM: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> IDLE.
- start outside IDLE is ignored; it is not queued.
- IDLE, start=1:
  - Register operands.
  - exp==0: operand is zero (denormals flushed), mantissa 0.
  - otherwise mantissa = {1, frac}.
- ALIGN:
  - Swap so the larger-magnitude operand is X, comparing {exp,frac}.
  - Extend both mantissas to 27 bits (24 + guard, round, sticky).
  - Right-shift Y by d = eX - eY; all shifted-out bits OR into sticky.
  - d>=27: Y becomes sticky-only (nonzero Y gives sticky=1).
  - Result sign = sign of X.
- ADDSUB:
  - Sign XOR = 0 -> 28-bit sum.
  - Sign XOR = 1 -> X - Y, which is never negative after the swap.
- NORM:
  - Bit27 set -> shift right 1, sticky preserved, exponent+1.
  - Otherwise left-shift by leading-zero count (0..26), exponent - count, computed in 10-bit signed.
  - Zero sum -> result +0 (exact cancellation always gives +0).
  - Exponent <= 0 -> flush to signed zero.
- ROUND (round-to-nearest-even):
  - Increment when G & (R | S | LSB).
  - If rounding carries out of the mantissa, exponent+1 and mantissa = 1.000.
  - Exponent >= 255 -> {sign, 8'hFF, 23'h0}.
  - Load result and assert done for this one enabled cycle.
- Special operands, detected in IDLE and carried through the FSM; latency stays fixed:
  - Any exp==255 operand (frac ignored, NaN inputs treated as inf) -> inf of that operand's sign.
  - inf + opposite-sign inf -> 32'h7FC00000.
- Latency: start accepted at enabled edge k -> done high after enabled edge k+4. The next start is accepted at edge k+5, giving 5 enabled cycles per operation.
- done falls after one enabled cycle; if clk_en is low during that cycle, done stays high.

Test Plan:
- dataa=3F800000, datab=40000000, start 1 cycle, clk_en=1 -> done exactly 4 cycles later, result=40400000; done low next cycle.
- 3F800000 + BF800000 -> 00000000. 40200000 + BF400000 (2.5 + -0.75) -> 3FE00000.
- Rounding:
  - 3F800000 + 33800000 (tie) -> 3F800000.
  - 3F800000 + 33800001 -> 3F800001.
  - 3F800001 + 33800000 (tie, odd LSB) -> 3F800002.
- 7F7FFFFF + 7F7FFFFF -> 7F800000. 7F800000 + FF800000 -> 7FC00000. 00400000 (denormal) + 00000000 -> 00000000.
- Handshake and reset:
  - clk_en low 3 cycles during NORM -> done 7 cycles after start, result unchanged while frozen.
  - start re-pulsed in ADDSUB is ignored.
  - reset pulse in ALIGN -> done=0, result=0, next start completes normally.
